// File: rtl/bp_predictor.sv
// Frontend branch predictor: direct-mapped BTB, optional 2-bit BHT and a
// circular return address stack. Prediction results are registered one cycle
// after the request; backend updates train the BTB and BHT.
// Build option: define BP_BHT_EN to include the BHT. Without it, sel 01 uses
// the BTB hit alone and the BHT part of an update is ignored.
module bp_predictor #(
  parameter int VLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  input  logic [VLEN-1:0] req_vpc_i,
  input  logic [1:0]      req_bp_sel_i,
  input  logic [1:0]      req_ras_ctl_i,
  input  logic            req_is_rvc_i,
  output logic            pred_valid_o,
  output logic [VLEN-1:0] pred_addr_o,
  input  logic            upd_valid_i,
  input  logic [1:0]      upd_bp_sel_i,
  input  logic [VLEN-1:0] upd_vpc_i,
  input  logic [VLEN-1:0] upd_addr_i,
  input  logic            upd_taken_i
);

  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = VLEN - BTB_IW - 1;
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam int CNT_W  = RAS_PW + 1;

  logic              btb_valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
  logic [VLEN-1:0]   btb_tgt_q   [BTB_ENTRIES];
  logic [VLEN-1:0]   ras_q       [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic              pred_valid_q, pred_valid_d;
  logic [VLEN-1:0]   pred_addr_q, pred_addr_d;

  logic [BTB_IW-1:0] req_bidx, upd_bidx;
  logic [TAG_W-1:0]  req_tag, upd_tag;
  logic              btb_hit, btb_wr, bht_taken;
  logic [RAS_PW-1:0] ras_top_idx, ras_widx;
  logic [VLEN-1:0]   ras_ret, ras_top;
  logic              ras_we, ras_empty, ras_full;

  assign req_bidx    = req_vpc_i[BTB_IW:1];
  assign req_tag     = req_vpc_i[VLEN-1:BTB_IW+1];
  assign upd_bidx    = upd_vpc_i[BTB_IW:1];
  assign upd_tag     = upd_vpc_i[VLEN-1:BTB_IW+1];
  assign btb_hit     = btb_valid_q[req_bidx] && (btb_tag_q[req_bidx] == req_tag);
  // Not-taken updates leave the BTB alone; only taken branches allocate.
  assign btb_wr      = upd_valid_i && !upd_bp_sel_i[1] && upd_taken_i;
  assign ras_top_idx = ras_ptr_q - RAS_PW'(1);
  assign ras_top     = ras_q[ras_top_idx];
  assign ras_ret     = req_vpc_i + (req_is_rvc_i ? VLEN'(2) : VLEN'(4));
  assign ras_empty   = (ras_cnt_q == '0);
  assign ras_full    = (ras_cnt_q == CNT_W'(RAS_DEPTH));

  // Bit 0 of a PC never takes part in indexing or tagging.
  logic unused_vpc;
  assign unused_vpc = ^{req_vpc_i[0], upd_vpc_i[0]};

`ifdef BP_BHT_EN
  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [BHT_IW-1:0] req_hidx, upd_hidx;
  logic              bht_wr;

  assign req_hidx  = req_vpc_i[BHT_IW:1];
  assign upd_hidx  = upd_vpc_i[BHT_IW:1];
  assign bht_wr    = upd_valid_i && (upd_bp_sel_i == 2'b01);
  assign bht_taken = bht_q[req_hidx][1];

  // BHT counters: weakly-not-taken at reset, saturating train on sel 01 updates
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_wr) begin
      if (upd_taken_i && bht_q[upd_hidx] != 2'b11) begin
        bht_q[upd_hidx] <= bht_q[upd_hidx] + 2'd1;
      end else if (!upd_taken_i && bht_q[upd_hidx] != 2'b00) begin
        bht_q[upd_hidx] <= bht_q[upd_hidx] - 2'd1;
      end
    end
  end
`else
  assign bht_taken = 1'b1;
  logic [31:0] unused_bht;
  assign unused_bht = BHT_ENTRIES ^ {31'd0, upd_bp_sel_i[0]};
`endif

  // Request decode: prediction result and RAS pointer/count/write for this cycle
  always_comb begin
    pred_valid_d = 1'b0;
    pred_addr_d  = pred_addr_q;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    ras_we       = 1'b0;
    ras_widx     = ras_ptr_q;
    if (flush_i) begin
      ras_ptr_d = '0;
      ras_cnt_d = '0;
    end else if (req_valid_i) begin
      case (req_bp_sel_i)
        2'b00: begin
          pred_valid_d = btb_hit;
          if (btb_hit) pred_addr_d = btb_tgt_q[req_bidx];
        end
        2'b01: begin
          pred_valid_d = btb_hit && bht_taken;
          if (btb_hit && bht_taken) pred_addr_d = btb_tgt_q[req_bidx];
        end
        2'b10: begin
          case (req_ras_ctl_i)
            2'b00: begin
              ras_we    = 1'b1;
              ras_ptr_d = ras_ptr_q + RAS_PW'(1);
              ras_cnt_d = ras_full ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
            end
            2'b01: begin
              if (!ras_empty) begin
                pred_valid_d = 1'b1;
                pred_addr_d  = ras_top;
                ras_ptr_d    = ras_top_idx;
                ras_cnt_d    = ras_cnt_q - CNT_W'(1);
              end
            end
            2'b10: begin
              // Pop+push replaces the top in place; on an empty stack it is a plain push.
              ras_we = 1'b1;
              if (ras_empty) begin
                ras_ptr_d = ras_ptr_q + RAS_PW'(1);
                ras_cnt_d = CNT_W'(1);
              end else begin
                pred_valid_d = 1'b1;
                pred_addr_d  = ras_top;
                ras_widx     = ras_top_idx;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Control state: prediction output register and RAS pointer/count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_q <= 1'b0;
      pred_addr_q  <= '0;
      ras_ptr_q    <= '0;
      ras_cnt_q    <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_addr_q  <= pred_addr_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
    end
  end

  // BTB valid bits; cleared on reset, which also discards a same-cycle update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_valid_q[upd_bidx] <= 1'b1;
    end
  end

  // BTB tag/target payload; meaningless while the valid bit is clear
  always_ff @(posedge clk_i) begin
    if (btb_wr) begin
      btb_tag_q[upd_bidx] <= upd_tag;
      btb_tgt_q[upd_bidx] <= upd_addr_i;
    end
  end

  // RAS payload; ptr/count decide which entries are live
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_q[ras_widx] <= ras_ret;
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_addr_o  = pred_addr_q;

endmodule

// File: tb/tb_bp_predictor.sv
// Bench for bp_predictor: queue/array reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bp_predictor;

`ifdef BP_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, flush_i, req_valid_i, req_is_rvc_i;
  logic [31:0] req_vpc_i;
  logic [1:0]  req_bp_sel_i, req_ras_ctl_i;
  logic        pred_valid_o;
  logic [31:0] pred_addr_o;
  logic        upd_valid_i, upd_taken_i;
  logic [1:0]  upd_bp_sel_i;
  logic [31:0] upd_vpc_i, upd_addr_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_predictor dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_vpc_i(req_vpc_i), .req_bp_sel_i(req_bp_sel_i),
    .req_ras_ctl_i(req_ras_ctl_i), .req_is_rvc_i(req_is_rvc_i),
    .pred_valid_o(pred_valid_o), .pred_addr_o(pred_addr_o),
    .upd_valid_i(upd_valid_i), .upd_bp_sel_i(upd_bp_sel_i), .upd_vpc_i(upd_vpc_i),
    .upd_addr_i(upd_addr_i), .upd_taken_i(upd_taken_i)
  );

  // Reference model: BTB keyed by full PC, BHT as integers, RAS as a bounded queue
  bit          m_bv   [16];
  logic [31:0] m_bpc  [16];
  logic [31:0] m_btgt [16];
  int          m_bht  [64];
  logic [31:0] m_ras  [$];
  logic        exp_valid;
  logic [31:0] exp_addr;
  bit          started = 1'b0;
  int          bi, hi, ui, uh;
  bit          hit, dir_ok;
  logic [31:0] ret;

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_ras.delete();
      exp_valid = 1'b0;
      exp_addr  = 32'h0;
      started   = 1'b1;
    end else begin
      bi     = int'((req_vpc_i >> 1) % 32'd16);
      hi     = int'((req_vpc_i >> 1) % 32'd64);
      hit    = m_bv[bi] && ((m_bpc[bi] >> 1) == (req_vpc_i >> 1));
      dir_ok = BHT ? (m_bht[hi] >= 2) : 1'b1;
      ret    = req_vpc_i + (req_is_rvc_i ? 32'd2 : 32'd4);
      exp_valid = 1'b0;
      if (flush_i) begin
        m_ras.delete();
      end else if (req_valid_i) begin
        if (req_bp_sel_i == 2'b00 && hit) begin
          exp_valid = 1'b1;
          exp_addr  = m_btgt[bi];
        end else if (req_bp_sel_i == 2'b01 && hit && dir_ok) begin
          exp_valid = 1'b1;
          exp_addr  = m_btgt[bi];
        end else if (req_bp_sel_i == 2'b10) begin
          if (req_ras_ctl_i == 2'b00 || (req_ras_ctl_i == 2'b10 && m_ras.size() == 0)) begin
            m_ras.push_back(ret);
            if (m_ras.size() > 8) void'(m_ras.pop_front());
          end else if (req_ras_ctl_i == 2'b01 && m_ras.size() > 0) begin
            exp_valid = 1'b1;
            exp_addr  = m_ras.pop_back();
          end else if (req_ras_ctl_i == 2'b10) begin
            exp_valid = 1'b1;
            exp_addr  = m_ras[$];
            m_ras[m_ras.size()-1] = ret;
          end
        end
      end
      if (upd_valid_i && upd_bp_sel_i[1] == 1'b0) begin
        ui = int'((upd_vpc_i >> 1) % 32'd16);
        uh = int'((upd_vpc_i >> 1) % 32'd64);
        if (upd_taken_i) begin
          m_bv[ui]   = 1'b1;
          m_bpc[ui]  = upd_vpc_i;
          m_btgt[ui] = upd_addr_i;
        end
        if (upd_bp_sel_i == 2'b01)
          m_bht[uh] = upd_taken_i ? ((m_bht[uh] < 3) ? m_bht[uh] + 1 : 3)
                                  : ((m_bht[uh] > 0) ? m_bht[uh] - 1 : 0);
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (pred_valid_o !== exp_valid) begin
        errors++;
        $display("FAIL model_valid t=%0t dut=%0b exp=%0b", $time, pred_valid_o, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (pred_addr_o !== exp_addr) begin
          errors++;
          $display("FAIL model_addr t=%0t dut=%h exp=%h", $time, pred_addr_o, exp_addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic v, input logic [31:0] a);
    checks++;
    if (pred_valid_o !== v) begin
      errors++;
      $display("FAIL %s valid dut=%0b exp=%0b", name, pred_valid_o, v);
    end
    if (v) begin
      checks++;
      if (pred_addr_o !== a) begin
        errors++;
        $display("FAIL %s addr dut=%h exp=%h", name, pred_addr_o, a);
      end
    end
  endtask

  task automatic clr();
    flush_i = 1'b0; req_valid_i = 1'b0; req_vpc_i = '0; req_bp_sel_i = 2'b11;
    req_ras_ctl_i = 2'b11; req_is_rvc_i = 1'b0; upd_valid_i = 1'b0;
    upd_bp_sel_i = 2'b11; upd_vpc_i = '0; upd_addr_i = '0; upd_taken_i = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] sel, input logic [1:0] ctl,
                         input logic [31:0] vpc, input logic rvc);
    req_valid_i = 1'b1; req_bp_sel_i = sel; req_ras_ctl_i = ctl;
    req_vpc_i = vpc; req_is_rvc_i = rvc;
  endtask

  task automatic set_upd(input logic [1:0] sel, input logic [31:0] vpc,
                         input logic [31:0] addr, input logic taken);
    upd_valid_i = 1'b1; upd_bp_sel_i = sel; upd_vpc_i = vpc;
    upd_addr_i = addr; upd_taken_i = taken;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rq(input logic [1:0] sel, input logic [1:0] ctl,
                    input logic [31:0] vpc, input logic rvc);
    clr(); set_req(sel, ctl, vpc, rvc); tick();
  endtask

  task automatic up(input logic [1:0] sel, input logic [31:0] vpc,
                    input logic [31:0] addr, input logic taken);
    clr(); set_upd(sel, vpc, addr, taken); tick();
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 1'b0, 32'h0);
    checks++;
    if (pred_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr dut=%h exp=%h", pred_addr_o, 32'h0);
    end
    rst_i = 1'b0;

    rq(2'b00, 2'b11, 32'h8000_0000, 1'b0); chk("cold_btb", 1'b0, 32'h0);

    up(2'b00, 32'h8000_0010, 32'h8000_0100, 1'b1);
    rq(2'b00, 2'b11, 32'h8000_0010, 1'b0); chk("btb_hit", 1'b1, 32'h8000_0100);
    rq(2'b00, 2'b11, 32'h9000_0010, 1'b0); chk("btb_tag_miss", 1'b0, 32'h0);
    clr(); set_upd(2'b00, 32'h8000_0034, 32'h8000_0340, 1'b1);
    set_req(2'b00, 2'b11, 32'h8000_0034, 1'b0); tick();
    chk("same_cycle_pre_update", 1'b0, 32'h0);
    rq(2'b00, 2'b11, 32'h8000_0034, 1'b0); chk("after_update", 1'b1, 32'h8000_0340);

    up(2'b01, 32'h8000_0020, 32'h8000_0200, 1'b1);
    up(2'b01, 32'h8000_0020, 32'h8000_0200, 1'b1);
    rq(2'b01, 2'b11, 32'h8000_0020, 1'b0); chk("bht_taken", 1'b1, 32'h8000_0200);
    up(2'b01, 32'h8000_0020, 32'h0, 1'b0);
    up(2'b01, 32'h8000_0020, 32'h0, 1'b0);
    rq(2'b01, 2'b11, 32'h8000_0020, 1'b0); chk("bht_not_taken", !BHT, 32'h8000_0200);
    rq(2'b00, 2'b11, 32'h8000_0020, 1'b0); chk("btb_kept", 1'b1, 32'h8000_0200);

    for (int k = 0; k < 3; k++) up(2'b01, 32'h8000_0064, 32'h8000_0640, 1'b1);
    up(2'b01, 32'h8000_0064, 32'h0, 1'b0);
    rq(2'b01, 2'b11, 32'h8000_0064, 1'b0); chk("bht_sat_hi", 1'b1, 32'h8000_0640);
    up(2'b01, 32'h8000_006C, 32'h0, 1'b0);
    up(2'b01, 32'h8000_006C, 32'h0, 1'b0);
    up(2'b01, 32'h8000_006C, 32'h8000_06C0, 1'b1);
    rq(2'b01, 2'b11, 32'h8000_006C, 1'b0); chk("bht_sat_lo", !BHT, 32'h8000_06C0);

    rq(2'b10, 2'b00, 32'h0000_1000, 1'b0); chk("push_a", 1'b0, 32'h0);
    rq(2'b10, 2'b00, 32'h0000_2000, 1'b1); chk("push_b", 1'b0, 32'h0);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("pop_b", 1'b1, 32'h0000_2002);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("pop_a", 1'b1, 32'h0000_1004);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("pop_empty", 1'b0, 32'h0);

    for (int k = 0; k <= 8; k++) rq(2'b10, 2'b00, 32'(k * 16), 1'b0);
    for (int k = 8; k >= 1; k--) begin
      rq(2'b10, 2'b01, 32'h0, 1'b0); chk("ras_wrap_pop", 1'b1, 32'(k * 16 + 4));
    end
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("ras_wrap_empty", 1'b0, 32'h0);

    rq(2'b10, 2'b00, 32'h0000_3000, 1'b0);
    clr(); flush_i = 1'b1;
    set_req(2'b00, 2'b11, 32'h8000_0010, 1'b0);
    set_upd(2'b00, 32'h8000_0046, 32'h8000_0460, 1'b1); tick();
    chk("flush_req_dropped", 1'b0, 32'h0);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("flush_ras_cleared", 1'b0, 32'h0);
    rq(2'b00, 2'b11, 32'h8000_0046, 1'b0); chk("flush_update_kept", 1'b1, 32'h8000_0460);

    rq(2'b10, 2'b00, 32'h0000_4000, 1'b0);
    rq(2'b10, 2'b10, 32'h0000_5000, 1'b1); chk("poppush_old_top", 1'b1, 32'h0000_4004);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("poppush_new_top", 1'b1, 32'h0000_5002);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("poppush_depth", 1'b0, 32'h0);
    rq(2'b10, 2'b10, 32'h0000_6000, 1'b0); chk("poppush_empty", 1'b0, 32'h0);
    rq(2'b10, 2'b01, 32'h0, 1'b0); chk("poppush_empty_pushed", 1'b1, 32'h0000_6004);

    rq(2'b11, 2'b00, 32'h8000_0010, 1'b0); chk("sel_none", 1'b0, 32'h0);
    rq(2'b10, 2'b11, 32'h8000_0010, 1'b0); chk("ras_nop", 1'b0, 32'h0);

    clr(); rst_i = 1'b1;
    set_upd(2'b00, 32'h8000_0050, 32'h8000_0500, 1'b1); tick();
    rst_i = 1'b0;
    rq(2'b00, 2'b11, 32'h8000_0050, 1'b0); chk("reset_drops_update", 1'b0, 32'h0);
    rq(2'b00, 2'b11, 32'h8000_0010, 1'b0); chk("reset_clears_btb", 1'b0, 32'h0);

    clr(); tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
